// File: rtl/spw_pkg.sv
// Shared SpaceWire definitions: control N-char codes, CRC-32/BZIP2
// constants and the state type of the receive CRC checker.
package spw_pkg;

  // N-char encoding: bit 8 set marks a control character
  localparam logic [8:0] SPW_EOP = 9'h100;
  localparam logic [8:0] SPW_EEP = 9'h101;

  // CRC-32, non-reflected, MSB-first, trailer sent MS byte first
  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  // Number of trailing bytes held back while the packet streams
  localparam int unsigned TRAILER_BYTES = 4;

  // FILL: fewer than 4 bytes buffered; STREAM: delay line full
  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } chk_state_e;

endpackage

// File: rtl/crc32_byte_next.sv
// Combinational CRC-32 byte step (MSB-first, non-reflected).
// Shared by the receive checker and the transmit-side generator.
module crc32_byte_next
  import spw_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Fold the byte into the top of the register, then shift out 8 bits
  always_comb begin
    logic [31:0] c;
    c = crc_i ^ {data_i, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      if (c[31]) begin
        c = {c[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/spw_rx_crc_check.sv
// Receive-side SpaceWire packet checker. Holds back the last 4 bytes of
// each packet (the CRC-32 trailer), forwards the payload and ends the
// packet with EOP on a CRC match or EEP otherwise.
// Optional macro SPW_CRC_ERRCNT_EN adds saturating err_cnt/pkt_cnt.
//
// Handshake: a char moves across an interface on any rising edge where
// valid && ready are both high; valid never depends on ready, and a
// producer holds its data stable while valid is high and ready is low.
// Here in_ready = !out_valid || out_ready, so the single output register
// can always take the result of an accepted input.
module spw_rx_crc_check
  import spw_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [8:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             runt_err,
`ifdef SPW_CRC_ERRCNT_EN
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
`endif
  output logic             dbg_state
);

  chk_state_e        state_q, state_d;
  logic [2:0]        fill_q, fill_d;
  logic [3:0][7:0]   dly_q, dly_d;      // dly[3] is the oldest byte
  logic [31:0]       crc_q, crc_d;
  logic [8:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              crc_ok_q, crc_ok_d;
  logic              crc_err_q, crc_err_d;
  logic              runt_err_q, runt_err_d;
  logic              term_load;         // a terminator enters the output register

  logic              accept;
  logic              is_eop;
  logic              crc_match;
  logic [31:0]       crc_fold;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_eop    = (in_data == SPW_EOP);
  // Trailer arrives MS byte first, so the oldest buffered byte is the MSB
  assign crc_match = ((crc_q ^ CRC32_XOROUT) == {dly_q[3], dly_q[2], dly_q[1], dly_q[0]});

  crc32_byte_next u_crc_next (
    .crc_i  (crc_q),
    .data_i (dly_q[3]),
    .crc_o  (crc_fold)
  );

  // Next-state: delay line, CRC, FSM and output register
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    dly_d       = dly_q;
    crc_d       = crc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    crc_ok_d    = 1'b0;
    crc_err_d   = 1'b0;
    runt_err_d  = 1'b0;
    term_load   = 1'b0;

    if (accept) begin
      if (!in_data[8]) begin
        dly_d = {dly_q[2:0], in_data[7:0]};
        unique case (state_q)
          ST_FILL: begin
            fill_d = fill_q + 3'd1;
            if (fill_q == 3'(TRAILER_BYTES - 1)) begin
              state_d = ST_STREAM;
            end
          end
          ST_STREAM: begin
            // Oldest byte is now known to be payload, not trailer
            out_data_d  = {1'b0, dly_q[3]};
            out_valid_d = 1'b1;
            crc_d       = crc_fold;
          end
          default: ;
        endcase
      end else begin
        // Any terminator closes the packet and rearms for the next one
        out_valid_d = 1'b1;
        term_load   = 1'b1;
        fill_d      = 3'd0;
        crc_d       = CRC32_INIT;
        state_d     = ST_FILL;
        if (is_eop && state_q == ST_STREAM) begin
          if (crc_match) begin
            out_data_d = SPW_EOP;
            crc_ok_d   = 1'b1;
          end else begin
            out_data_d = SPW_EEP;
            crc_err_d  = 1'b1;
          end
        end else if (is_eop) begin
          out_data_d = SPW_EEP;
          runt_err_d = 1'b1;
        end else begin
          // EEP or unknown control code: link already reported it
          out_data_d = SPW_EEP;
        end
      end
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      fill_q      <= 3'd0;
      dly_q       <= '0;
      crc_q       <= CRC32_INIT;
      out_data_q  <= 9'h000;
      out_valid_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      runt_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      dly_q       <= dly_d;
      crc_q       <= crc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      runt_err_q  <= runt_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign runt_err  = runt_err_q;
  assign dbg_state = state_q;

`ifdef SPW_CRC_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] pkt_cnt_q;

  // Saturating counters, updated on the edge that loads the terminator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if ((crc_err_d || runt_err_d) && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      if (term_load && (pkt_cnt_q != '1)) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
    end
  end

  assign err_cnt = err_cnt_q;
  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_spw_rx_crc_check.sv
// Bench for spw_rx_crc_check: a vector table for the fixed packets plus
// streamed sequences for back-pressure and reset-mid-packet.
module tb_spw_rx_crc_check;

  localparam logic [8:0] EOP = 9'h100;
  localparam logic [8:0] EEP = 9'h101;

  logic        clk;
  logic        rst_n;
  logic [8:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        crc_ok;
  logic        crc_err;
  logic        runt_err;
  logic        dbg_state;
`ifdef SPW_CRC_ERRCNT_EN
  logic [15:0] err_cnt;
  logic [15:0] pkt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  spw_rx_crc_check #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .runt_err  (runt_err),
`ifdef SPW_CRC_ERRCNT_EN
    .err_cnt   (err_cnt),
    .pkt_cnt   (pkt_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent bitwise CRC-32/BZIP2 step for building trailers
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[31] ^ b[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [8:0] din;
    logic       vld;
    logic       exp_vld;
    logic [8:0] exp_data;
    logic       exp_ok;
    logic       exp_err;
    logic       exp_runt;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] pkt_b[$];

  task automatic add_vec(input logic [8:0] din, input logic vld, input logic ev,
                         input logic [8:0] ed, input logic ok, input logic err,
                         input logic runt);
    vec_t v;
    v.din = din; v.vld = vld; v.exp_vld = ev; v.exp_data = ed;
    v.exp_ok = ok; v.exp_err = err; v.exp_runt = runt;
    vecs.push_back(v);
  endtask

  // Bytes of pkt_b in order; byte k appears at the output as byte k-4
  task automatic add_pkt(input logic [8:0] term, input logic [8:0] exp_term,
                         input logic ok, input logic err, input logic runt);
    for (int k = 0; k < pkt_b.size(); k++) begin
      if (k >= 4) add_vec({1'b0, pkt_b[k]}, 1'b1, 1'b1, {1'b0, pkt_b[k-4]}, 1'b0, 1'b0, 1'b0);
      else        add_vec({1'b0, pkt_b[k]}, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    end
    add_vec(term, 1'b1, 1'b1, exp_term, ok, err, runt);
    pkt_b.delete();
  endtask

  task automatic load_check_pkt(input logic [7:0] b4);
    for (int i = 0; i < 9; i++) pkt_b.push_back(8'(8'h31 + i));
    pkt_b[4] = b4;
    pkt_b.push_back(8'hFC); pkt_b.push_back(8'h89);
    pkt_b.push_back(8'h19); pkt_b.push_back(8'h18);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid  = vecs[i].vld;
      in_data   = vecs[i].din;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d crc_ok", i),   32'(crc_ok),   32'(vecs[i].exp_ok));
      chk($sformatf("v%0d crc_err", i),  32'(crc_err),  32'(vecs[i].exp_err));
      chk($sformatf("v%0d runt_err", i), 32'(runt_err), 32'(vecs[i].exp_runt));
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 9'h000;
  endtask

  // ---------------- streamed driver + scoreboard ----------------
  logic [8:0] tx_q[$];
  logic [8:0] exp_q[$];

  task automatic queue_good_pkt(input int n, input logic rnd);
    logic [31:0] c;
    logic [31:0] t;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom_range(255)) : 8'(8'h31 + i);
      c = crc_step(c, b);
      tx_q.push_back({1'b0, b});
      exp_q.push_back({1'b0, b});
    end
    t = ~c;
    tx_q.push_back({1'b0, t[31:24]});
    tx_q.push_back({1'b0, t[23:16]});
    tx_q.push_back({1'b0, t[15:8]});
    tx_q.push_back({1'b0, t[7:0]});
    tx_q.push_back(EOP);
    exp_q.push_back(EOP);
  endtask

  task automatic run_stream(input string tag, input int rdy_pct, input int exp_ok_n);
    int ok_n;
    int err_n;
    int runt_n;
    int cyc;
    logic [8:0] e;
    ok_n = 0; err_n = 0; runt_n = 0; cyc = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(99) < rdy_pct);
      if (tx_q.size() != 0) begin
        in_valid = 1'b1;
        in_data  = tx_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 9'h000;
      end
      #1;
      chk({tag, " in_ready"}, 32'(in_ready), 32'(!out_valid || out_ready));
      if (in_valid && in_ready) void'(tx_q.pop_front());
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s extra_char: got 0x%0h expected none", tag, out_data);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " out_data"}, 32'(out_data), 32'(e));
        end
      end
      if (crc_ok)   ok_n++;
      if (crc_err)  err_n++;
      if (runt_err) runt_n++;
    end
    chk({tag, " drained"}, 32'(tx_q.size() + exp_q.size()), 32'd0);
    tx_q.delete();
    exp_q.delete();
    // let the final output register empty before judging pulse counts
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    if (crc_ok)   ok_n++;
    if (crc_err)  err_n++;
    if (runt_err) runt_n++;
    chk({tag, " crc_ok count"},   32'(ok_n),   32'(exp_ok_n));
    chk({tag, " crc_err count"},  32'(err_n),  32'd0);
    chk({tag, " runt_err count"}, 32'(runt_n), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    in_data   = 9'h000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data",  32'(out_data),  32'd0);
    chk("rst crc_ok",    32'(crc_ok),    32'd0);
    chk("rst crc_err",   32'(crc_err),   32'd0);
    chk("rst runt_err",  32'(runt_err),  32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst state",     32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: good, corrupted, runt, aborted, good again
    load_check_pkt(8'h35);
    add_pkt(EOP, EOP, 1'b1, 1'b0, 1'b0);
    add_vec(9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    load_check_pkt(8'h36);
    add_pkt(EOP, EEP, 1'b0, 1'b1, 1'b0);
    pkt_b.push_back(8'hAA); pkt_b.push_back(8'hBB);
    add_pkt(EOP, EEP, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) pkt_b.push_back(8'(8'h10 + i));
    add_pkt(EEP, EEP, 1'b0, 1'b0, 1'b0);
    load_check_pkt(8'h35);
    add_pkt(EOP, EOP, 1'b1, 1'b0, 1'b0);
    // unknown control code on an otherwise empty packet behaves as EEP
    add_vec(9'h1A5, 1'b1, 1'b1, EEP, 1'b0, 1'b0, 1'b0);
    add_vec(9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    run_table();
`ifdef SPW_CRC_ERRCNT_EN
    #1;
    chk("err_cnt", 32'(err_cnt), 32'd2);
    chk("pkt_cnt", 32'(pkt_cnt), 32'd6);
`endif

    // 64 random bytes, valid CRC, 50% back-pressure
    queue_good_pkt(64, 1'b1);
    run_stream("bp64", 50, 1);

    // Reset after 5 bytes of a packet
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = {1'b0, 8'(8'h31 + i)};
      out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    chk("pre-rst out_data",  32'(out_data),  32'h031);
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst in_ready",  32'(in_ready),  32'd1);
    chk("mid-rst state",     32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid-rst hold out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    queue_good_pkt(9, 1'b0);
    run_stream("post_rst", 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spw_rx_crc_check.md
# spw_rx_crc_check

Receive-side packet integrity checker for the SpaceWire data path. Consumes N-chars drained from the receive `synfifo`, strips the 4-byte CRC-32 trailer appended by the transmit-side generator, and checks it against a CRC computed over the payload. Forwards the payload unchanged and terminates the packet with EOP if the CRC matches, or EEP if it does not. Sits between the receive FIFO and the host interface.

## Interface
- Parameter `CNT_W`, default 16: width of the optional error/packet counters.
- `clk`  in  1  single system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  9  N-char. Bit 8 = 0 is a data byte in [7:0]. Bit 8 = 1 is a control char: [7:0] = 0x00 is EOP, 0x01 is EEP.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  checker accepts `in_data` this cycle.
- `out_data`  out  9  forwarded N-char, same encoding as `in_data`.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `crc_ok`  out  1  one-cycle pulse: a good EOP was loaded into the output.
- `crc_err`  out  1  one-cycle pulse: a CRC mismatch was detected.
- `runt_err`  out  1  one-cycle pulse: packet had fewer than 4 bytes before EOP.
- `err_cnt`, `pkt_cnt`  out  CNT_W each  counters; present only with the macro (see Configuration).

## Operation
- Accept rule: `in_ready = !out_valid || out_ready`. A transfer occurs when `in_valid && in_ready`.
- Delay line: 4-entry byte shift register `dly[0..3]` plus a fill count `fill` (0..4).
- CRC: CRC-32, polynomial 0x04C11DB7, non-reflected, processed MSB-first. Register initialised to 0xFFFFFFFF at packet start. Final XOR is 0xFFFFFFFF. The trailer is sent most-significant byte first (CRC-32/BZIP2).
- Accepted data byte, `fill < 4`: shift into `dly` and increment `fill`. No output is produced.
- Accepted data byte, `fill == 4`: load the oldest byte `dly[3]` into the output register with bit 8 = 0, and fold it into the CRC register. Shift the new byte in.
- Accepted EOP, `fill == 4`: compare `~crc` with `{dly[3],dly[2],dly[1],dly[0]}`.
  - Equal: output EOP and pulse `crc_ok`.
  - Not equal: output EEP and pulse `crc_err`.
- Accepted EOP, `fill < 4`: output EEP and pulse `runt_err`. Buffered bytes are discarded.
- Accepted EEP: output EEP, discard buffered bytes, no error pulse (the link layer already flagged it).
- After any terminator: set `fill = 0` and `crc = 0xFFFFFFFF` in the same edge. The next byte starts a new packet.
- Unknown control code (bit 8 = 1, [7:0] > 1): treated as EEP.
- Each accepted input produces at most one output char, so a single output register suffices.
- FSM states (internal, one-hot allowed):
  - `FILL`: `fill < 4`; moves to `STREAM` when the 4th byte is accepted.
  - `STREAM`: `fill == 4`; returns to `FILL` on any terminator.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `crc_ok = crc_err = runt_err = 0`, `fill = 0`, `crc = 0xFFFFFFFF`, counters 0.
- `in_ready` is 1 immediately after reset.
- Latency: a char accepted at edge N appears on `out_data`/`out_valid` after edge N.
- Output transfer and new input may occur in the same cycle. Full throughput is one char per clock.
- `out_valid` clears only on `out_ready`, or when an accept that produces no output occurs while `out_ready` is high.
- Pulses `crc_ok`/`crc_err`/`runt_err` assert in the cycle `out_valid` first shows the terminator, regardless of `out_ready`.
- Reset mid-packet: all state is cleared asynchronously and a partly held output is lost. The first post-reset byte starts a new packet.

## Configuration
- `SPW_CRC_ERRCNT_EN` defined:
  - `err_cnt` increments on `crc_err` or `runt_err`.
  - `pkt_cnt` increments on every terminator output.
  - Both are saturating at all-ones.
- Not defined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `spw_pkg`: `SPW_EOP` = 9'h100, `SPW_EEP` = 9'h101, `CRC32_POLY`, `CRC32_INIT`, `CRC32_XOROUT`.
- Sub-module `crc32_byte_next`: combinational (crc[31:0], byte[7:0]) -> next crc. Reusable by the transmit-side generator.

## Test plan
- Bytes "123456789" (0x31..0x39), then 0xFC 0x89 0x19 0x18, then EOP, with `out_ready = 1` -> output is 0x31..0x39 then EOP; `crc_ok` pulses once; no EEP.
- Same packet with byte 0x35 changed to 0x36 -> 9 bytes, then EEP; `crc_err` pulses; `err_cnt` = 1 with the macro.
- Bytes 0xAA 0xBB, then EOP -> no data output, a single EEP, `runt_err` pulse.
- Random `out_ready` back-pressure (50%) on a 64-byte packet with valid CRC -> payload identical and in order, EOP, no char dropped or duplicated.
- 6 bytes, then EEP -> outputs 2 bytes then EEP, no error pulse. Next packet is checked from a fresh CRC state.
- Assert `rst_n` low after 5 bytes of a packet, then send the valid "123456789" packet -> `out_valid` is 0 during reset; the following packet passes with `crc_ok`.
